div_arbiter: RTL and testbench

Shares one iterative divider (32-bit dividend/divisor, valid/ready in and out) between N requesters. The arbiter picks a requester round-robin and issues its operands to the divider. It keeps exactly one operation in flight and returns quotient/remainder to the owning requester. It sits between the requesting units and the single divider instance.

---
 rtl/div_arbiter.sv | 153 +++++++++++++++
 tb/tb_div_arbiter.sv | 469 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_arbiter.sv
// Round-robin share of one iterative divider among N requesters, one operation in flight; grant->div_valid_in 1 cycle, result->rsp_valid 1 cycle.
// Backpressure: stalls in ISSUE on div_ready_out and in RESP on rsp_ready[owner]; no grants outside IDLE.
module div_arbiter #(
  parameter int N   = 4,
  parameter int W   = 32,
  parameter int IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_valid,
  output logic [N-1:0]   req_ready,
  input  logic [N*W-1:0] req_dividend,
  input  logic [N*W-1:0] req_divisor,
  output logic [N-1:0]   rsp_valid,
  input  logic [N-1:0]   rsp_ready,
  output logic [W-1:0]   rsp_quotient,
  output logic [W-1:0]   rsp_remainder,
  output logic           div_valid_in,
  input  logic           div_ready_out,
  output logic [W-1:0]   div_dividend,
  output logic [W-1:0]   div_divisor,
  input  logic           div_valid_out,
  output logic           div_ready_in,
  input  logic [W-1:0]   div_quotient,
  input  logic [W-1:0]   div_remainder,
  output logic           busy,
  output logic [IDW-1:0] owner
);

  localparam int CW = IDW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  typedef struct packed {
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
  } op_t;

  typedef struct packed {
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
  } res_t;

  state_t         state;
  logic [IDW-1:0] rr_ptr;
  op_t            op_q;
  res_t           res_q;

  logic           grant_any;
  logic [IDW-1:0] grant_idx;
  logic [IDW-1:0] next_ptr;
  logic [CW-1:0]  cand;
  op_t            grant_op;
  logic [N-1:0]   owner_oh;

  // First valid requester at or after rr_ptr, wrapping explicitly at N (N need not be a power of two).
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, rr_ptr} + CW'(k);
      if (cand >= CW'(N)) begin
        cand = cand - CW'(N);
      end
      if (!grant_any && req_valid[cand[IDW-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    grant_op = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_idx == IDW'(i)) begin
        grant_op.dividend = req_dividend[i*W +: W];
        grant_op.divisor  = req_divisor[i*W +: W];
      end
    end
  end

  assign next_ptr = (grant_idx == IDW'(N - 1)) ? '0 : grant_idx + 1'b1;

  always_comb begin
    owner_oh        = '0;
    owner_oh[owner] = 1'b1;
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && grant_any && !rst) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      owner        <= '0;
      op_q         <= '0;
      res_q        <= '0;
      busy         <= 1'b0;
      div_valid_in <= 1'b0;
      div_ready_in <= 1'b0;
      rsp_valid    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            op_q         <= grant_op;
            owner        <= grant_idx;
            rr_ptr       <= next_ptr;
            state        <= ISSUE;
            busy         <= 1'b1;
            div_valid_in <= 1'b1;
          end
        end
        ISSUE: begin
          if (div_ready_out) begin
            state        <= WAIT;
            div_valid_in <= 1'b0;
            div_ready_in <= 1'b1;
          end
        end
        WAIT: begin
          if (div_valid_out) begin
            res_q.quotient  <= div_quotient;
            res_q.remainder <= div_remainder;
            state           <= RESP;
            div_ready_in    <= 1'b0;
            rsp_valid       <= owner_oh;
          end
        end
        RESP: begin
          if (|(rsp_valid & rsp_ready)) begin
            state     <= IDLE;
            rsp_valid <= '0;
            busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign div_dividend  = op_q.dividend;
  assign div_divisor   = op_q.divisor;
  assign rsp_quotient  = (state == RESP) ? res_q.quotient : '0;
  assign rsp_remainder = (state == RESP) ? res_q.remainder : '0;

endmodule

// File: tb/tb_div_arbiter.sv
// Bench for div_arbiter: N=4 instance against a transaction-level model plus divider stub, and an N=3 instance for wrap-around.
`timescale 1ns/1ps
module tb_div_arbiter;

  localparam int N   = 4;
  localparam int W   = 32;
  localparam int IDW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic [N-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*W-1:0] req_dividend, req_divisor;
  logic [W-1:0]   rsp_quotient, rsp_remainder, div_dividend, div_divisor;
  logic [W-1:0]   div_quotient, div_remainder;
  logic           div_valid_in, div_ready_out, div_valid_out, div_ready_in, busy;
  logic [IDW-1:0] owner;

  logic [2:0]     r3_req_valid, r3_req_ready, r3_rsp_valid;
  logic [2:0]     r3_rsp_ready = 3'b111;
  logic [3*W-1:0] r3_dividend = {32'd22, 32'd21, 32'd20};
  logic [3*W-1:0] r3_divisor  = {32'd3, 32'd3, 32'd3};
  logic [W-1:0]   r3_q, r3_r, r3_ddd, r3_dds, r3_dq, r3_dr;
  logic           r3_vi, r3_ro, r3_vo, r3_ri, r3_busy, r3_sbusy;
  logic [1:0]     r3_owner;

  int checks = 0;
  int failures = 0;

  div_arbiter #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder),
    .div_valid_in(div_valid_in), .div_ready_out(div_ready_out),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_valid_out(div_valid_out), .div_ready_in(div_ready_in),
    .div_quotient(div_quotient), .div_remainder(div_remainder),
    .busy(busy), .owner(owner)
  );

  div_arbiter #(.N(3), .W(W)) dut3 (
    .clk(clk), .rst(rst),
    .req_valid(r3_req_valid), .req_ready(r3_req_ready),
    .req_dividend(r3_dividend), .req_divisor(r3_divisor),
    .rsp_valid(r3_rsp_valid), .rsp_ready(r3_rsp_ready),
    .rsp_quotient(r3_q), .rsp_remainder(r3_r),
    .div_valid_in(r3_vi), .div_ready_out(r3_ro),
    .div_dividend(r3_ddd), .div_divisor(r3_dds),
    .div_valid_out(r3_vo), .div_ready_in(r3_ri),
    .div_quotient(r3_dq), .div_remainder(r3_dr),
    .busy(r3_busy), .owner(r3_owner)
  );

  function automatic logic [W-1:0] ref_q(input logic [W-1:0] a, input logic [W-1:0] b);
    return (b == 0) ? '1 : a / b;
  endfunction

  function automatic logic [W-1:0] ref_r(input logic [W-1:0] a, input logic [W-1:0] b);
    return (b == 0) ? a : a % b;
  endfunction

  function automatic int pick(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic int idx_of(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      if (v[k]) return k;
    end
    return -1;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Divider stub for the N=4 instance: configurable latency and an input stall control.
  logic         stub_busy, stub_block;
  int           stub_lat, stub_cnt;
  logic [N-1:0] rsp_hold;
  assign div_ready_out = !stub_busy && !stub_block;
  assign rsp_ready     = ~rsp_hold;

  always @(posedge clk) begin
    if (rst) begin
      stub_busy     <= 1'b0;
      div_valid_out <= 1'b0;
      stub_cnt      <= 0;
      div_quotient  <= '0;
      div_remainder <= '0;
    end else if (!stub_busy) begin
      if (div_valid_in && div_ready_out) begin
        stub_busy     <= 1'b1;
        stub_cnt      <= stub_lat;
        div_quotient  <= ref_q(div_dividend, div_divisor);
        div_remainder <= ref_r(div_dividend, div_divisor);
      end
    end else if (!div_valid_out) begin
      if (stub_cnt <= 1) div_valid_out <= 1'b1;
      else stub_cnt <= stub_cnt - 1;
    end else if (div_ready_in) begin
      div_valid_out <= 1'b0;
      stub_busy     <= 1'b0;
    end
  end

  assign r3_ro = !r3_sbusy;
  always @(posedge clk) begin
    if (rst) begin
      r3_sbusy <= 1'b0;
      r3_vo    <= 1'b0;
      r3_dq    <= '0;
      r3_dr    <= '0;
    end else if (!r3_sbusy) begin
      if (r3_vi) begin
        r3_sbusy <= 1'b1;
        r3_vo    <= 1'b1;
        r3_dq    <= ref_q(r3_ddd, r3_dds);
        r3_dr    <= ref_r(r3_ddd, r3_dds);
      end
    end else if (r3_vo && r3_ri) begin
      r3_vo    <= 1'b0;
      r3_sbusy <= 1'b0;
    end
  end

  // Requester agent: each requester presents its queued operations in order, advancing on handshake.
  logic [W-1:0] op_a [N][16];
  logic [W-1:0] op_b [N][16];
  int head [N];
  int tail [N];

  task automatic push(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    op_a[i][tail[i]] = a;
    op_b[i][tail[i]] = b;
    tail[i]++;
  endtask

  initial begin
    logic [N-1:0] hs;
    for (int i = 0; i < N; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    forever begin
      @(negedge clk);
      hs = req_valid & req_ready;
      @(posedge clk);
      #2;
      for (int i = 0; i < N; i++) begin
        if (hs[i]) head[i]++;
        if (head[i] < tail[i]) begin
          req_valid[i]           = 1'b1;
          req_dividend[i*W +: W] = op_a[i][head[i]];
          req_divisor[i*W +: W]  = op_b[i][head[i]];
        end else begin
          req_valid[i]           = 1'b0;
          req_dividend[i*W +: W] = '0;
          req_divisor[i*W +: W]  = '0;
        end
      end
    end
  end

  // Model: where the single outstanding operation stands (0 none, 1 offered to divider, 2 computing, 3 answered).
  logic         chk_en;
  int           m_stage, m_ptr, m_owner;
  logic [W-1:0] m_a, m_b, m_q, m_r;
  int           glog[$];
  int           rlog_idx[$];
  logic [W-1:0] rlog_q[$], rlog_r[$], mlog_q[$], mlog_r[$];
  int           g3[$];
  logic [W-1:0] q3[$], rr3[$];

  initial begin
    int g;
    logic [N-1:0] e_rr, e_rv;
    m_stage = 0; m_ptr = 0; m_owner = 0;
    m_a = '0; m_b = '0; m_q = '0; m_r = '0;
    forever begin
      @(negedge clk);
      g = pick(req_valid, m_ptr);
      if (chk_en) begin
        e_rr = '0;
        if (!rst && m_stage == 0 && g >= 0) e_rr[g] = 1'b1;
        e_rv = '0;
        if (m_stage == 3) e_rv[m_owner] = 1'b1;
        chk("req_ready", req_ready, e_rr);
        chk("busy", busy, m_stage != 0);
        chk("owner", owner, m_owner);
        chk("div_valid_in", div_valid_in, m_stage == 1);
        chk("div_ready_in", div_ready_in, m_stage == 2);
        chk("rsp_valid", rsp_valid, e_rv);
        chk("rsp_quotient", rsp_quotient, (m_stage == 3) ? m_q : '0);
        chk("rsp_remainder", rsp_remainder, (m_stage == 3) ? m_r : '0);
        if (m_stage == 1) begin
          chk("div_dividend", div_dividend, m_a);
          chk("div_divisor", div_divisor, m_b);
        end
        if (|(req_valid & req_ready)) glog.push_back(idx_of(req_valid & req_ready));
        if (|(rsp_valid & rsp_ready)) begin
          rlog_idx.push_back(idx_of(rsp_valid & rsp_ready));
          rlog_q.push_back(rsp_quotient);
          rlog_r.push_back(rsp_remainder);
        end
      end
      if (rst) begin
        m_stage = 0; m_ptr = 0; m_owner = 0;
        m_a = '0; m_b = '0; m_q = '0; m_r = '0;
      end else begin
        case (m_stage)
          0: if (g >= 0) begin
            m_owner = g;
            m_ptr   = (g + 1) % N;
            m_a     = req_dividend[g*W +: W];
            m_b     = req_divisor[g*W +: W];
            m_stage = 1;
          end
          1: if (div_ready_out) m_stage = 2;
          2: if (div_valid_out) begin
            m_q = ref_q(m_a, m_b);
            m_r = ref_r(m_a, m_b);
            m_stage = 3;
          end
          default: if (rsp_ready[m_owner]) begin
            mlog_q.push_back(m_q);
            mlog_r.push_back(m_r);
            m_stage = 0;
          end
        endcase
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int k = 0; k < 3; k++) begin
          if (r3_req_valid[k] && r3_req_ready[k]) g3.push_back(k);
        end
        if (|(r3_rsp_valid & r3_rsp_ready)) begin
          q3.push_back(r3_q);
          rr3.push_back(r3_r);
        end
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic clear_logs();
    glog.delete(); rlog_idx.delete(); rlog_q.delete(); rlog_r.delete();
    mlog_q.delete(); mlog_r.delete();
  endtask

  task automatic wait_rsp(input int n, input string nm);
    int c = 0;
    do begin
      @(posedge clk);
      c++;
    end while (rlog_q.size() < n && c < 400);
    #1;
    chk(nm, rlog_q.size() >= n, 1);
  endtask

  task automatic run3(input logic [2:0] v, input int target);
    logic [2:0] gm;
    int c = 0;
    r3_req_valid = v;
    while (q3.size() < target && c < 200) begin
      @(negedge clk);
      gm = r3_req_valid & r3_req_ready;
      @(posedge clk);
      #1;
      r3_req_valid = r3_req_valid & ~gm;
      c++;
    end
    chk("n3_progress", q3.size() >= target, 1);
  endtask

  logic [W-1:0] f_a [8] = '{32'd1000, 32'd99, 32'd123456, 32'd255, 32'd77, 32'd0, 32'd5, 32'hFFFF_FFFF};
  logic [W-1:0] f_b [8] = '{32'd10, 32'd4, 32'd1000, 32'd16, 32'd8, 32'd5, 32'd0, 32'd2};
  logic [W-1:0] f_q [8] = '{32'd100, 32'd24, 32'd123, 32'd15, 32'd9, 32'd0, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
  logic [W-1:0] f_r [8] = '{32'd0, 32'd3, 32'd456, 32'd15, 32'd5, 32'd0, 32'd5, 32'd1};

  initial begin
    bit found;
    rst = 1'b1; chk_en = 1'b0;
    req_valid = '0; req_dividend = '0; req_divisor = '0;
    rsp_hold = '0; stub_block = 1'b0; stub_lat = 3;
    r3_req_valid = '0;
    sync();
    chk_en = 1'b1;
    tick(2);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    chk("rst_div_dividend", div_dividend, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_div_valid_in", div_valid_in, 0);
    sync();

    // Single request 13/3.
    clear_logs();
    push(0, 32'd13, 32'd3);
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (req_ready[0]) found = 1;
    end
    chk("t1_grant_seen", found, 1);
    @(negedge clk);
    chk("t1_issue_next_cycle", div_valid_in, 1);
    wait_rsp(1, "t1_timeout");
    chk("t1_nrsp", rlog_q.size(), 1);
    chk("t1_idx", rlog_idx[0], 0);
    chk("t1_q", rlog_q[0], 4);
    chk("t1_r", rlog_r[0], 1);
    chk("t1_model_q", mlog_q[0], 4);

    // Simultaneous requests after reset.
    do_reset();
    clear_logs();
    push(0, 32'd100, 32'd7);
    push(1, 32'd50, 32'd5);
    wait_rsp(2, "t2_timeout");
    chk("t2_grant0", glog[0], 0);
    chk("t2_grant1", glog[1], 1);
    chk("t2_q0", rlog_q[0], 14);
    chk("t2_r0", rlog_r[0], 2);
    chk("t2_q1", rlog_q[1], 10);
    chk("t2_r1", rlog_r[1], 0);
    chk("t2_model_r0", mlog_r[0], 2);

    // Fairness with all requesters continuously valid.
    do_reset();
    clear_logs();
    for (int k = 0; k < 8; k++) push(k % 4, f_a[k], f_b[k]);
    wait_rsp(8, "t3_timeout");
    chk("t3_ngrant", glog.size(), 8);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("t3_grant%0d", k), glog[k], k % 4);
      chk($sformatf("t3_q%0d", k), rlog_q[k], f_q[k]);
      chk($sformatf("t3_r%0d", k), rlog_r[k], f_r[k]);
    end

    // Response backpressure on requester 2 with requester 0 waiting.
    clear_logs();
    rsp_hold = 4'b0100;
    push(2, 32'd40, 32'd6);
    found = 0;
    for (int c = 0; c < 50 && !found; c++) begin
      @(negedge clk);
      if (rsp_valid[2]) found = 1;
    end
    chk("t4_rsp_seen", found, 1);
    sync();
    push(0, 32'd9, 32'd2);
    repeat (9) @(negedge clk);
    chk("t4_hold_valid", rsp_valid, 4'b0100);
    chk("t4_hold_q", rsp_quotient, 6);
    chk("t4_hold_r", rsp_remainder, 4);
    chk("t4_hold_req_ready", req_ready, 0);
    chk("t4_hold_busy", busy, 1);
    sync();
    rsp_hold = '0;
    wait_rsp(2, "t4_timeout");
    chk("t4_idx0", rlog_idx[0], 2);
    chk("t4_idx1", rlog_idx[1], 0);
    chk("t4_q1", rlog_q[1], 4);
    chk("t4_r1", rlog_r[1], 1);

    // Divider input stall.
    clear_logs();
    stub_block = 1'b1;
    stub_lat = 2;
    push(1, 32'd81, 32'd9);
    repeat (6) @(negedge clk);
    chk("t5_stall_valid", div_valid_in, 1);
    chk("t5_stall_dividend", div_dividend, 81);
    chk("t5_stall_divisor", div_divisor, 9);
    sync();
    stub_block = 1'b0;
    wait_rsp(1, "t5_timeout");
    chk("t5_idx", rlog_idx[0], 1);
    chk("t5_q", rlog_q[0], 9);
    chk("t5_r", rlog_r[0], 0);

    // Reset while the divider is computing.
    clear_logs();
    stub_lat = 8;
    push(3, 32'd100, 32'd9);
    found = 0;
    for (int c = 0; c < 30 && !found; c++) begin
      @(negedge clk);
      if (div_ready_in) found = 1;
    end
    chk("t6_wait_seen", found, 1);
    sync();
    rst = 1'b1;
    sync();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_busy", busy, 0);
    chk("t6_rsp_valid", rsp_valid, 0);
    chk("t6_req_ready", req_ready, 0);
    chk("t6_div_valid_in", div_valid_in, 0);
    sync();
    stub_lat = 3;
    push(2, 32'd13, 32'd3);
    wait_rsp(1, "t6_timeout");
    tick(5);
    chk("t6_nrsp", rlog_q.size(), 1);
    chk("t6_idx", rlog_idx[0], 2);
    chk("t6_q", rlog_q[0], 4);
    chk("t6_r", rlog_r[0], 1);

    // Wrap-around on the N=3 instance.
    do_reset();
    run3(3'b010, 1);
    run3(3'b101, 3);
    run3(3'b011, 5);
    chk("n3_ngrant", g3.size(), 5);
    chk("n3_g0", g3[0], 1);
    chk("n3_g1", g3[1], 2);
    chk("n3_g2", g3[2], 0);
    chk("n3_g3", g3[3], 1);
    chk("n3_g4", g3[4], 0);
    chk("n3_q1", q3[1], 7);
    chk("n3_r1", rr3[1], 1);
    chk("n3_q2", q3[2], 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
